// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 registered-feedback bus bundle between a master and the burst
// block-RAM slave. clk/rst travel separately as plain ports.
interface wb_bram_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADR_WIDTH-1:0]      adr;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic [DATA_WIDTH-1:0]     dat_ms;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic [DATA_WIDTH-1:0]     dat_sm;
  logic                      ack;
  logic                      err;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  dat_sm, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output dat_sm, ack, err
  );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave: byte-lane writes with combinational ack, registered
// reads with zero-wait-state constant/incrementing (linear, wrap-4/8/16) bursts.
module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_bram_burst_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(NB);
  localparam int TOP   = MEM_ADR_WIDTH + BSH;
  localparam int DEPTH = 2 ** MEM_ADR_WIDTH;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;

  typedef logic [MEM_ADR_WIDTH-1:0] wadr_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic                  rd_ack_q, rd_ack_d;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  load;
  wadr_t                 rd_adr;

  logic  req, oor, rd_req, wr_req, burst_cti;
  wadr_t wa, wa_inc, wrap_mask, na;
  logic  unused_adr_bits;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign req = bus.cyc & bus.stb;
  assign wa  = bus.adr[TOP-1:BSH];

  // Byte-offset bits are deliberately ignored; fold them somewhere harmless.
  assign unused_adr_bits = ^bus.adr;

  generate
    if (ADR_WIDTH > TOP) begin : g_oor
      assign oor = |bus.adr[ADR_WIDTH-1:TOP];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign rd_req    = req & ~bus.we & ~oor;
  assign wr_req    = req &  bus.we & ~oor & ~rst;
  assign burst_cti = (bus.cti == CTI_CONST) || (bus.cti == CTI_INCR);

  // ---------------------------------------------------------------------------
  // Next beat address: the beat after the one currently presented
  // ---------------------------------------------------------------------------
  assign wa_inc = wa + wadr_t'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wrap_mask = '1;
    case (bus.bte)
      2'b01:   wrap_mask = wadr_t'(4'h3);
      2'b10:   wrap_mask = wadr_t'(4'h7);
      2'b11:   wrap_mask = wadr_t'(4'hF);
      default: wrap_mask = '1;
    endcase
  end

  // Wrapping bursts only advance the low bits; linear bursts roll over the depth.
  assign na = (bus.cti == CTI_CONST) ? wa : ((wa & ~wrap_mask) | (wa_inc & wrap_mask));

  // ---------------------------------------------------------------------------
  // Read FSM: next state and prefetch control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_ack_d = 1'b0;
    load     = 1'b0;
    rd_adr   = wa;
    case (state_q)
      IDLE: begin
        // rd_ack_q high means this request is being acked now; do not re-launch it.
        if (rd_req && !rd_ack_q) begin
          load     = 1'b1;
          rd_ack_d = 1'b1;
          if (burst_cti) state_d = BURST;
        end
      end
      BURST: begin
        // End-of-burst, wait states, writes, classic/reserved cti and oor all leave here.
        if (rd_req && burst_cti) begin
          load     = 1'b1;
          rd_ack_d = 1'b1;
          rd_adr   = na;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      rd_ack_q <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ack_q <= rd_ack_d;
      if (load) dat_q <= mem[rd_adr];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array, byte-lane writes
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset so it maps onto block RAM; only control and output registers reset.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.sel[i]) mem[wa][8*i +: 8] <= bus.dat_ms[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: a registered read ack only counts while its read is still presented
  // ---------------------------------------------------------------------------
  assign bus.dat_sm = dat_q;
  assign bus.ack    = wr_req | (rd_ack_q & rd_req);
  assign bus.err    = req & oor & ~rst;

endmodule
